// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory stage: funct3 codes, FSM states, size decode.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RMW   = 2'd2,
        STORE = 2'd3
    } state_t;

    // Access size in bytes; the low two funct3 bits encode log2(size).
    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   size_bytes = 4'd1;
            2'b01:   size_bytes = 4'd2;
            2'b10:   size_bytes = 4'd4;
            default: size_bytes = 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port 2**DEPTH_LOG2 x 64 synchronous RAM, registered read, no reset.
// Latency: read data valid one cycle after the address; write commits at the edge.
// Backpressure: none, one access per cycle.
module dmem_ram #(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [63:0]           wdata,
    output logic [63:0]           rdata
);

    logic [63:0] mem [2**DEPTH_LOG2];

    // Write-first is not needed: readers never depend on same-edge write data.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory stage: byte/half/word/double loads and stores with RMW merge; optional DMEM_MISALIGN_TRAP_EN.
// Latency: rsp_valid exactly one cycle after accept; load data driven on d_mem_data that cycle only.
// Backpressure: req_ready low during the single response cycle, so at most one access per two cycles.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 6,
    parameter int ADDR_W     = DEPTH_LOG2 + 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    inout  wire  [63:0]       d_mem_data,
    output logic              rsp_valid,
    output logic              err
);

    state_t state_q, state_d;

    logic [DEPTH_LOG2-1:0] idx_q;
    logic [2:0]            f3_q;
    logic [2:0]            off_q;
    logic [63:0]           st_data_q;
    logic                  err_q;

    logic                  ram_we;
    logic [DEPTH_LOG2-1:0] ram_idx;
    logic [63:0]           ram_wdata;
    logic [63:0]           ram_rdata;
    logic                  load_drv;

    // Request decode
    logic [3:0] size_b;
    logic [2:0] lo_mask;
    logic       unsup;
    logic       misal;
    logic       bad;
    logic [2:0] off;

    assign size_b  = size_bytes(req_funct3);
    assign lo_mask = 3'(size_b - 4'd1);
    assign unsup   = req_we ? req_funct3[2] : (req_funct3 == 3'b111);
    assign misal   = (req_addr[2:0] & lo_mask) != 3'd0;

`ifdef DMEM_MISALIGN_TRAP_EN
    assign bad = unsup | misal;
    assign off = req_addr[2:0];
`else
    // Misaligned accesses are silently realigned to the access size.
    assign bad = unsup;
    assign off = req_addr[2:0] & ~lo_mask;
`endif

    // Load lane select and extension
    logic [63:0] lane;
    logic [63:0] ext;
    logic [63:0] load_data;

    assign lane = ram_rdata >> {off_q, 3'b000};

    // Sign/zero extension of the selected lane; error responses return zero.
    always_comb begin
        ext = lane;
        case (f3_q)
            F3_B:    ext = {{56{lane[7]}},  lane[7:0]};
            F3_H:    ext = {{48{lane[15]}}, lane[15:0]};
            F3_W:    ext = {{32{lane[31]}}, lane[31:0]};
            F3_BU:   ext = {56'd0, lane[7:0]};
            F3_HU:   ext = {48'd0, lane[15:0]};
            F3_WU:   ext = {32'd0, lane[31:0]};
            default: ext = lane;
        endcase
        load_data = err_q ? 64'd0 : ext;
    end

    assign d_mem_data = load_drv ? load_data : 64'bz;

    // Store merge: replace only the latched bytes of the freshly read word
    logic [63:0] byte_mask;
    logic [63:0] bit_mask;
    logic [63:0] merged;

    // Byte-lane mask for the latched store size, shifted to its offset.
    always_comb begin
        case (f3_q[1:0])
            2'b00:   byte_mask = 64'h0000_0000_0000_00FF;
            2'b01:   byte_mask = 64'h0000_0000_0000_FFFF;
            2'b10:   byte_mask = 64'h0000_0000_FFFF_FFFF;
            default: byte_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        bit_mask = byte_mask << {off_q, 3'b000};
        merged   = (ram_rdata & ~bit_mask) | ((st_data_q << {off_q, 3'b000}) & bit_mask);
    end

    // State register; reset overrides any in-flight access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the request context whenever a request is presented while idle.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && req_valid) begin
            idx_q     <= req_addr[ADDR_W-1:3];
            f3_q      <= req_funct3;
            off_q     <= off;
            st_data_q <= d_mem_data;
            err_q     <= bad;
        end
    end

    // Next state, handshake outputs and RAM port control.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        err       = 1'b0;
        ram_we    = 1'b0;
        ram_idx   = req_addr[ADDR_W-1:3];
        ram_wdata = d_mem_data;
        load_drv  = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (bad) begin
                        state_d = req_we ? STORE : LOAD;
                    end else if (!req_we) begin
                        state_d = LOAD;
                    end else if (req_funct3 == F3_D) begin
                        ram_we  = 1'b1;
                        state_d = STORE;
                    end else begin
                        state_d = RMW;
                    end
                end
            end
            LOAD: begin
                rsp_valid = 1'b1;
                err       = err_q;
                load_drv  = 1'b1;
                state_d   = IDLE;
            end
            RMW: begin
                rsp_valid = 1'b1;
                err       = err_q;
                ram_idx   = idx_q;
                ram_wdata = merged;
                ram_we    = ~err_q;
                state_d   = IDLE;
            end
            default: begin
                rsp_valid = 1'b1;
                err       = err_q;
                state_d   = IDLE;
            end
        endcase
        if (reset) begin
            ram_we = 1'b0;
        end
    end

    dmem_ram #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_idx),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_dmem_ctrl.sv
// Randomized + directed bench for dmem_ctrl with a byte-array reference model and response scoreboard.
// Latency: checks every response lands exactly one cycle after its accept.
// Backpressure: drives requests and holds them until req_ready accepts them.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [8:0]  req_addr;
    wire  [63:0] d_mem_data;
    logic        rsp_valid;
    logic        err;

    logic        tb_oe;
    logic [63:0] tb_drv;

    assign d_mem_data = tb_oe ? tb_drv : 64'bz;

    always #5 clk = ~clk;

    dmem_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .d_mem_data (d_mem_data),
        .rsp_valid  (rsp_valid),
        .err        (err)
    );

    typedef struct {
        logic        is_load;
        logic [63:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t   exp_q[$];
    string  name_q[$];
    logic [7:0] mbytes [512];
    int     n_chk  = 0;
    int     n_fail = 0;
    int     cyc    = 0;
    bit     mon_en = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, want);
        end
    endtask

    // Reference model: byte-addressed memory, access rules computed directly.
    function automatic void model(input logic we, input logic [2:0] f3, input logic [8:0] addr,
                                  input logic [63:0] data, input bit apply,
                                  output logic [63:0] rd, output logic er);
        int sz;
        int a;
        bit unsup;
        bit mis;
        sz    = 1 << f3[1:0];
        unsup = we ? (f3 > 3'd3) : (f3 == 3'd7);
        mis   = (int'(addr) % sz) != 0;
        rd    = 64'd0;
`ifdef DMEM_MISALIGN_TRAP_EN
        er = unsup || mis;
        a  = int'(addr);
`else
        er = unsup;
        a  = int'(addr) - (int'(addr) % sz);
`endif
        if (!er) begin
            if (we) begin
                if (apply) for (int i = 0; i < sz; i++) mbytes[a + i] = data[8*i +: 8];
            end else begin
                for (int i = 0; i < sz; i++) rd = rd | (64'(mbytes[a + i]) << (8 * i));
                if (f3 < 3'd4 && sz < 8 && mbytes[a + sz - 1][7]) rd = rd | (~64'd0 << (8 * sz));
            end
        end
    endfunction

    // Present one request, hold it until accepted, and queue its expected response.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [8:0] addr,
                         input logic [63:0] data, input string name, input bit use_k,
                         input logic [63:0] k_data, input logic k_err, input bit apply,
                         output int waits);
        exp_t        e;
        logic [63:0] md;
        logic        me;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        tb_drv     = data;
        tb_oe      = 1'b0;
        waits      = 0;
        while (!req_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        if (!req_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s accept_timeout: req_ready stayed 0 for 20 cycles, required 1", name);
            req_valid = 1'b0;
            return;
        end
        tb_oe = we;
        model(we, f3, addr, data, apply, md, me);
        e.is_load = !we;
        e.data    = use_k ? k_data : md;
        e.err     = use_k ? k_err : me;
        e.cyc     = cyc + 1;
        exp_q.push_back(e);
        name_q.push_back(name);
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req_valid = 1'b0;
            tb_oe     = 1'b0;
        end
    endtask

    // Scoreboard monitor: every response must match the oldest outstanding request.
    exp_t  m_e;
    string m_n;
    always @(negedge clk) begin
        if (mon_en && rsp_valid) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_rsp: got rsp_valid=1, required no response");
            end else begin
                m_e = exp_q.pop_front();
                m_n = name_q.pop_front();
                chk({m_n, " latency_cycle"}, 64'(cyc), 64'(m_e.cyc));
                chk({m_n, " err"}, {63'd0, err}, {63'd0, m_e.err});
                chk({m_n, " busy_ready"}, {63'd0, req_ready}, 64'd0);
                if (m_e.is_load) chk({m_n, " data"}, d_mem_data, m_e.data);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [63:0] rnd;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 9'd0;
        tb_oe      = 1'b0;
        tb_drv     = 64'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset req_ready", {63'd0, req_ready}, 64'd1);
        chk("reset rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("reset err",       {63'd0, err},       64'd0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Directed lane/extension/merge cases on word 0x010
        issue(1, 3'd3, 9'h010, 64'h8899AABBCCDDEEFF, "SD_010", 0, 0, 0, 1, w);
        issue(0, 3'd3, 9'h010, 0, "LD_010",  1, 64'h8899AABBCCDDEEFF, 0, 1, w);
        issue(0, 3'd0, 9'h017, 0, "LB_017",  1, 64'hFFFFFFFFFFFFFF88, 0, 1, w);
        issue(0, 3'd4, 9'h017, 0, "LBU_017", 1, 64'h0000000000000088, 0, 1, w);
        issue(0, 3'd1, 9'h014, 0, "LH_014",  1, 64'hFFFFFFFFFFFFAABB, 0, 1, w);
        issue(0, 3'd6, 9'h010, 0, "LWU_010", 1, 64'h00000000CCDDEEFF, 0, 1, w);
        issue(1, 3'd0, 9'h011, 64'hDEADBEEFCAFE0042, "SB_011", 0, 0, 0, 1, w);
        issue(0, 3'd3, 9'h010, 0, "LD_after_SB", 1, 64'h8899AABBCCDD42FF, 0, 1, w);
        issue(1, 3'd2, 9'h014, 64'h7777777701020304, "SW_014", 0, 0, 0, 1, w);
        issue(0, 3'd3, 9'h010, 0, "LD_after_SW", 1, 64'h01020304CCDD42FF, 0, 1, w);
`ifdef DMEM_MISALIGN_TRAP_EN
        issue(0, 3'd1, 9'h013, 0, "LH_013_misaligned", 1, 64'd0, 1, 1, w);
`else
        issue(0, 3'd1, 9'h013, 0, "LH_013_misaligned", 1, 64'hFFFFFFFFFFFFCCDD, 0, 1, w);
`endif
        issue(0, 3'd7, 9'h010, 0, "LD_f3_111", 1, 64'd0, 1, 1, w);
        issue(1, 3'd5, 9'h010, 64'h1111111111111111, "ST_f3_101", 0, 0, 0, 1, w);
        issue(0, 3'd3, 9'h010, 0, "LD_after_bad_store", 1, 64'h01020304CCDD42FF, 0, 1, w);
        idle(2);

        // Give every RAM word a known value
        for (int i = 0; i < 64; i++) begin
            rnd = {$urandom, $urandom};
            issue(1, 3'd3, 9'(i * 8), rnd, "init_SD", 0, 0, 0, 1, w);
        end

        // Reset during the RMW cycle must suppress the merge write
        issue(1, 3'd0, 9'h018, 64'h0000000000000055, "SB_018_reset", 0, 0, 0, 0, w);
        @(negedge clk);
        req_valid = 1'b0;
        tb_oe     = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        chk("rsp_valid after reset", {63'd0, rsp_valid}, 64'd0);
        chk("req_ready after reset", {63'd0, req_ready}, 64'd1);
        reset = 1'b0;
        issue(0, 3'd3, 9'h018, 0, "LD_018_unchanged", 0, 0, 0, 1, w);

        // Continuous req_valid with alternating SD/LD: ready must toggle every cycle
        for (int k = 0; k < 8; k++) begin
            rnd = {$urandom, $urandom};
            if (k % 2 == 0) issue(1, 3'd3, 9'h020, rnd, "toggle_SD", 0, 0, 0, 1, w);
            else            issue(0, 3'd3, 9'h020, 0,   "toggle_LD", 0, 0, 0, 1, w);
            if (k > 0) chk("ready_toggle busy_cycles", 64'(w), 64'd1);
        end
        idle(1);

        // Random mix of all sizes, signs, alignments and unsupported codes
        for (int n = 0; n < 300; n++) begin
            rnd = {$urandom, $urandom};
            issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 9'($urandom_range(0, 511)),
                  rnd, "rand", 0, 0, 0, 1, w);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end

        idle(4);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL outstanding_rsp: got %0d responses missing, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
